skeleton_line_drawer: RTL and testbench

- Consumes the decoded pose frame from the SPI receive stage (four 10-bit joint points P1..P4 plus 4-bit r/g/b) and rasterises three line segments, P1-P2, P2-P3 and P3-P4, using Bresenham stepping.
- Emits one pixel-write request per drawn pixel with valid/ready backpressure toward the VGA framebuffer writer.
- Sits between the SPI frame decoder and the framebuffer.

---
 rtl/skel_pkg.sv | 23 ++
 rtl/bresenham_stepper.sv | 95 +++++++++
 rtl/skeleton_line_drawer.sv | 147 ++++++++++++++
 tb/tb_skeleton_line_drawer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/skel_pkg.sv
// Shared types and defaults for the skeleton line rasteriser.
package skel_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned H_RES   = 640;
    localparam int unsigned V_RES   = 480;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDraw,
        StNext,
        StDone
    } state_t;

    typedef logic [11:0] color_t;

endpackage

// File: rtl/bresenham_stepper.sv
// Bresenham walker for one segment: load latches the endpoints, adv takes one step.
module bresenham_stepper #(
    parameter int unsigned COORD_W = skel_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               adv_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] x1_i,
    input  logic [COORD_W-1:0] y1_i,
    output logic [COORD_W-1:0] cur_x_o,
    output logic [COORD_W-1:0] cur_y_o,
    output logic               at_end_o
);

    localparam int unsigned ErrW = COORD_W + 2;
    localparam logic [COORD_W-1:0] One = 1;

    logic [COORD_W-1:0]     cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_W-1:0]     end_x_q, end_x_d, end_y_q, end_y_d;
    logic signed [ErrW-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d;
    logic                   sx_q, sx_d, sy_q, sy_d;
    logic [COORD_W-1:0]     adx, ady;
    logic signed [ErrW:0]   e2, dx_ext, dy_ext;

    assign at_end_o = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
    assign cur_x_o  = cur_x_q;
    assign cur_y_o  = cur_y_q;

    assign adx    = (x1_i >= x0_i) ? (x1_i - x0_i) : (x0_i - x1_i);
    assign ady    = (y1_i >= y0_i) ? (y1_i - y0_i) : (y0_i - y1_i);
    assign e2     = {err_q, 1'b0};
    assign dx_ext = {dx_q[ErrW-1], dx_q};
    assign dy_ext = {dy_q[ErrW-1], dy_q};

    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        end_x_d = end_x_q;
        end_y_d = end_y_q;
        err_d   = err_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        if (load_i) begin
            dx_d    = $signed({2'b00, adx});
            dy_d    = -$signed({2'b00, ady});
            err_d   = $signed({2'b00, adx}) - $signed({2'b00, ady});
            sx_d    = (x1_i >= x0_i);
            sy_d    = (y1_i >= y0_i);
            cur_x_d = x0_i;
            cur_y_d = y0_i;
            end_x_d = x1_i;
            end_y_d = y1_i;
        end else if (adv_i && !at_end_o) begin
            // Both tests use e2 from the pre-step error so a diagonal step is possible.
            if (e2 >= dy_ext) begin
                err_d   = err_d + dy_q;
                cur_x_d = sx_q ? (cur_x_q + One) : (cur_x_q - One);
            end
            if (e2 <= dx_ext) begin
                err_d   = err_d + dx_q;
                cur_y_d = sy_q ? (cur_y_q + One) : (cur_y_q - One);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x_q <= '0;
            cur_y_q <= '0;
            end_x_q <= '0;
            end_y_q <= '0;
            err_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
        end else begin
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            end_x_q <= end_x_d;
            end_y_q <= end_y_d;
            err_q   <= err_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

endmodule

// File: rtl/skeleton_line_drawer.sv
// Rasterises P1-P2, P2-P3, P3-P4 of a pose frame into clipped pixel-write requests.
module skeleton_line_drawer #(
    parameter int unsigned COORD_W = skel_pkg::COORD_W,
    parameter int unsigned H_RES   = skel_pkg::H_RES,
    parameter int unsigned V_RES   = skel_pkg::V_RES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic [COORD_W-1:0] x_1,
    input  logic [COORD_W-1:0] y_1,
    input  logic [COORD_W-1:0] x_2,
    input  logic [COORD_W-1:0] y_2,
    input  logic [COORD_W-1:0] x_3,
    input  logic [COORD_W-1:0] y_3,
    input  logic [COORD_W-1:0] x_4,
    input  logic [COORD_W-1:0] y_4,
    input  logic [3:0]         r,
    input  logic [3:0]         g,
    input  logic [3:0]         b,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [11:0]        px_color,
    output logic               busy,
    output logic               frame_done
);

    import skel_pkg::*;

    state_t             state_q, state_d;
    logic [1:0]         seg_q, seg_d;
    logic [COORD_W-1:0] xs_q [4];
    logic [COORD_W-1:0] ys_q [4];
    color_t             color_q;
    logic               accept, load, adv, on_screen, at_end;
    logic [COORD_W-1:0] x0, y0, x1, y1, cur_x, cur_y;

    always_comb begin
        x0 = xs_q[0];
        y0 = ys_q[0];
        x1 = xs_q[1];
        y1 = ys_q[1];
        unique case (seg_q)
            2'd1: begin
                x0 = xs_q[1]; y0 = ys_q[1]; x1 = xs_q[2]; y1 = ys_q[2];
            end
            2'd2: begin
                x0 = xs_q[2]; y0 = ys_q[2]; x1 = xs_q[3]; y1 = ys_q[3];
            end
            default: ;
        endcase
    end

    bresenham_stepper #(
        .COORD_W(COORD_W)
    ) u_stepper (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .adv_i   (adv),
        .x0_i    (x0),
        .y0_i    (y0),
        .x1_i    (x1),
        .y1_i    (y1),
        .cur_x_o (cur_x),
        .cur_y_o (cur_y),
        .at_end_o(at_end)
    );

    assign on_screen = (cur_x < COORD_W'(H_RES)) && (cur_y < COORD_W'(V_RES));
    assign px_x      = cur_x;
    assign px_y      = cur_y;
    assign px_color  = color_q;
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        accept      = 1'b0;
        load        = 1'b0;
        adv         = 1'b0;
        frame_ready = 1'b0;
        px_valid    = 1'b0;
        frame_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    accept  = 1'b1;
                    seg_d   = 2'd0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                load    = 1'b1;
                state_d = StDraw;
            end
            StDraw: begin
                px_valid = on_screen;
                // Clipped pixels step without waiting for the framebuffer.
                if (!on_screen || px_ready) begin
                    if (at_end) state_d = StNext;
                    else        adv     = 1'b1;
                end
            end
            StNext: begin
                if (seg_q == 2'd2) begin
                    state_d = StDone;
                end else begin
                    seg_d   = seg_q + 2'd1;
                    state_d = StLoad;
                end
            end
            StDone: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            seg_q   <= 2'd0;
            color_q <= '0;
            for (int i = 0; i < 4; i++) begin
                xs_q[i] <= '0;
                ys_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            if (accept) begin
                color_q <= {r, g, b};
                xs_q[0] <= x_1; ys_q[0] <= y_1;
                xs_q[1] <= x_2; ys_q[1] <= y_2;
                xs_q[2] <= x_3; ys_q[2] <= y_3;
                xs_q[3] <= x_4; ys_q[3] <= y_4;
            end
        end
    end

endmodule

// File: tb/tb_skeleton_line_drawer.sv
// Self-checking bench: table cases, random frames against a pixel-list model, corner sequences.
module tb_skeleton_line_drawer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_valid = 1'b0;
    logic       frame_ready;
    logic [9:0] x_1 = '0, y_1 = '0, x_2 = '0, y_2 = '0;
    logic [9:0] x_3 = '0, y_3 = '0, x_4 = '0, y_4 = '0;
    logic [3:0] r = '0, g = '0, b = '0;
    logic       px_valid;
    logic       px_ready = 1'b0;
    logic [9:0] px_x, px_y;
    logic [11:0] px_color;
    logic       busy, frame_done;

    skeleton_line_drawer dut (
        .clk        (clk),
        .reset      (reset),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .x_1        (x_1),
        .y_1        (y_1),
        .x_2        (x_2),
        .y_2        (y_2),
        .x_3        (x_3),
        .y_3        (y_3),
        .x_4        (x_4),
        .y_4        (y_4),
        .r          (r),
        .g          (g),
        .b          (b),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_color   (px_color),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    typedef struct {
        int    xs[4];
        int    ys[4];
        int    rgb;
        int    mode;   // 0: ready high, 1: toggle 1-0, 2: random
        int    exp_n;  // -1 when not fixed by the table
        string name;
    } vec_t;

    pix_t exp_q[$];
    pix_t got_q[$];
    int   n_assert = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input int ax1, input int ay1, input int ax2, input int ay2,
                                   input int ax3, input int ay3, input int ax4, input int ay4,
                                   input int rgb, input int mode, input int exp_n,
                                   input string name);
        vec_t v;
        v.xs[0] = ax1; v.ys[0] = ay1; v.xs[1] = ax2; v.ys[1] = ay2;
        v.xs[2] = ax3; v.ys[2] = ay3; v.xs[3] = ax4; v.ys[3] = ay4;
        v.rgb = rgb; v.mode = mode; v.exp_n = exp_n; v.name = name;
        return v;
    endfunction

    // Reference: textbook Bresenham on integers, inclusive endpoints, off-screen points dropped.
    task automatic model_seg(input int xa, input int ya, input int xb, input int yb, input int c);
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (xb > xa) ? xb - xa : xa - xb;
        dy  = -((yb > ya) ? yb - ya : ya - yb);
        sx  = (xa < xb) ? 1 : -1;
        sy  = (ya < yb) ? 1 : -1;
        err = dx + dy;
        x   = xa;
        y   = ya;
        forever begin
            if (x < 640 && y < 480) exp_q.push_back('{x, y, c});
            if (x == xb && y == yb) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic model_frame(input vec_t v);
        exp_q.delete();
        for (int s = 0; s < 3; s++) model_seg(v.xs[s], v.ys[s], v.xs[s+1], v.ys[s+1], v.rgb);
    endtask

    task automatic present(input vec_t v);
        @(negedge clk);
        chk({v.name, "_frame_ready_idle"}, int'(frame_ready), 1);
        x_1 = 10'(v.xs[0]); y_1 = 10'(v.ys[0]); x_2 = 10'(v.xs[1]); y_2 = 10'(v.ys[1]);
        x_3 = 10'(v.xs[2]); y_3 = 10'(v.ys[2]); x_4 = 10'(v.xs[3]); y_4 = 10'(v.ys[3]);
        r = 4'(v.rgb >> 8); g = 4'(v.rgb >> 4); b = 4'(v.rgb);
        frame_valid = 1'b1;
        @(posedge clk);
        #1 frame_valid = 1'b0;
    endtask

    // Collects handshaken pixels until frame_done; optionally injects a frame while busy
    // or returns early after abort_after handshakes.
    task automatic collect(input string name, input int mode, input int inject_at,
                           input int abort_after, output int aborted);
        int cyc = 0;
        bit done = 0;
        bit stall = 0;
        int hx = 0, hy = 0;
        aborted = 0;
        got_q.delete();
        while (!done && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (abort_after >= 0 && got_q.size() == abort_after) begin
                aborted = 1;
                break;
            end
            if (stall) begin
                chk({name, "_hold_valid"}, int'(px_valid), 1);
                chk({name, "_hold_x"}, int'(px_x), hx);
                chk({name, "_hold_y"}, int'(px_y), hy);
            end
            if (cyc == inject_at) begin
                chk({name, "_frame_ready_busy"}, int'(frame_ready), 0);
                x_1 = 10'd300; y_1 = 10'd300; x_2 = 10'd310; y_2 = 10'd305;
                x_3 = 10'd320; y_3 = 10'd290; x_4 = 10'd330; y_4 = 10'd300;
                r = 4'h0; g = 4'hF; b = 4'h0;
                frame_valid = 1'b1;
            end
            if (cyc == inject_at + 4) frame_valid = 1'b0;
            if (frame_done) done = 1;
            case (mode)
                0:       px_ready = 1'b1;
                1:       px_ready = (cyc % 2) == 1;
                default: px_ready = 1'($urandom_range(0, 1));
            endcase
            if (px_valid && px_ready) got_q.push_back('{int'(px_x), int'(px_y), int'(px_color)});
            stall = px_valid && !px_ready;
            hx    = int'(px_x);
            hy    = int'(px_y);
        end
        if (!aborted) begin
            chk({name, "_frame_done_seen"}, int'(done), 1);
            if (done) begin
                @(negedge clk);
                chk({name, "_busy_after"}, int'(busy), 0);
                chk({name, "_ready_after"}, int'(frame_ready), 1);
                chk({name, "_done_single"}, int'(frame_done), 0);
            end
        end
    endtask

    task automatic compare(input string name);
        int n;
        chk({name, "_pix_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_px%0d_x", name, i), got_q[i].x, exp_q[i].x);
            chk($sformatf("%s_px%0d_y", name, i), got_q[i].y, exp_q[i].y);
            chk($sformatf("%s_px%0d_color", name, i), got_q[i].c, exp_q[i].c);
        end
    endtask

    vec_t table_v[4];
    vec_t horiz, v;
    int   ab;

    initial begin
        horiz      = mkvec(0, 0, 9, 0, 9, 0, 9, 0, 'hF00, 0, 12, "horizontal");
        table_v[0] = horiz;
        table_v[1] = mkvec(0, 0, 4, 4, 4, 4, 4, 4, 'h0A5, 0, 7, "diagonal");
        table_v[2] = mkvec(0, 0, 9, 0, 9, 0, 9, 0, 'hF00, 1, 12, "backpressure");
        table_v[3] = mkvec(636, 0, 643, 0, 643, 0, 643, 0, 'h123, 0, 4, "clipping");

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_frame_ready", int'(frame_ready), 1);
        chk("reset_px_valid", int'(px_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_px_x", int'(px_x), 0);
        chk("reset_px_y", int'(px_y), 0);
        chk("reset_px_color", int'(px_color), 0);

        foreach (table_v[i]) begin
            present(table_v[i]);
            collect(table_v[i].name, table_v[i].mode, -1, -1, ab);
            chk({table_v[i].name, "_table_count"}, got_q.size(), table_v[i].exp_n);
            model_frame(table_v[i]);
            compare(table_v[i].name);
        end

        // A frame offered while drawing must be dropped.
        present(horiz);
        collect("busy_drop", 0, 4, -1, ab);
        model_frame(horiz);
        compare("busy_drop");
        repeat (3) @(negedge clk);
        chk("busy_drop_no_restart", int'(busy), 0);

        // Reset after three handshakes aborts the frame.
        present(horiz);
        collect("reset_mid", 0, -1, 3, ab);
        chk("reset_mid_aborted", ab, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_px_valid", int'(px_valid), 0);
        chk("reset_mid_busy", int'(busy), 0);
        chk("reset_mid_frame_ready", int'(frame_ready), 1);
        v = mkvec(100, 200, 103, 197, 110, 199, 110, 199, 'h777, 0, -1, "after_reset");
        present(v);
        collect(v.name, 0, -1, -1, ab);
        model_frame(v);
        compare(v.name);

        for (int k = 0; k < 8; k++) begin
            v = mkvec(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                      int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                      int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                      int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                      int'($urandom_range(0, 4095)), int'($urandom_range(0, 2)), -1,
                      $sformatf("random%0d", k));
            present(v);
            collect(v.name, v.mode, -1, -1, ab);
            model_frame(v);
            compare(v.name);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
